// File: rtl/fp_mult_bist.sv
// fp_mult_bist -- built-in self test sequencer for a floating-point multiplier.
// Drives a fixed table of IEEE-754 corner operands under every rounding mode,
// waits out the multiplier latency and folds each result and status byte into
// a 32-bit MISR whose final value is compared against GOLDEN_SIG.
// Optional build macro FP_BIST_RANDOM_EN appends a pseudo-random phase
// (RAND_COUNT vectors per rounding mode) sourced from a Galois LFSR.
module fp_mult_bist #(
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000,
    parameter int unsigned RAND_COUNT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [2:0]  rnd_o,
    input  logic [31:0] z_i,
    input  logic [7:0]  status_i,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] vec_count,
    output logic [31:0] signature
);

    localparam logic [31:0] SIG_INIT = 32'hFFFF_FFFF;

`ifdef FP_BIST_RANDOM_EN
    localparam int unsigned RANDOM_EN = 1;
`else
    localparam int unsigned RANDOM_EN = 0;
`endif

    // Largest vector count a complete run can reach; the counter saturates there.
    localparam int unsigned VEC_MAX   = 864 + 6 * RAND_COUNT * RANDOM_EN;
    localparam logic [10:0] VEC_MAX_W = 11'(VEC_MAX);

    // WAIT lasts LATENCY cycles (LATENCY >= 1 assumed).
    localparam int unsigned         WAIT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    // Corner operands: sNaN, qNaN, infinities, +/-1.0, smallest subnormals, zeros.
    function automatic logic [31:0] corner_val(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0:    v = 32'h7FA0_0000;
            4'd1:    v = 32'hFFA0_0000;
            4'd2:    v = 32'h7FC0_0000;
            4'd3:    v = 32'hFFC0_0000;
            4'd4:    v = 32'h7F80_0000;
            4'd5:    v = 32'hFF80_0000;
            4'd6:    v = 32'h3F80_0000;
            4'd7:    v = 32'hBF80_0000;
            4'd8:    v = 32'h0000_0001;
            4'd9:    v = 32'h8000_0001;
            4'd10:   v = 32'h0000_0000;
            4'd11:   v = 32'h8000_0000;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [2:0]        r_mode;
    logic [3:0]        r_i;
    logic [3:0]        r_j;

    logic              w_j_last;
    logic              w_i_last;
    logic              w_corner_last;
    logic              w_run_last;
    logic [2:0]        w_mode_n;
    logic [3:0]        w_i_n;
    logic [3:0]        w_j_n;
    logic [31:0]       w_a_n;
    logic [31:0]       w_b_n;
    logic [2:0]        w_rnd_n;
    logic [31:0]       w_sig_next;

`ifdef FP_BIST_RANDOM_EN
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
    localparam int unsigned RC_W      = (RAND_COUNT > 1) ? $clog2(RAND_COUNT) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAND_COUNT - 1);

    // Right-shifting Galois step: the bit shifted out selects the tap mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

    logic              r_phase;   // 0 corner phase, 1 random phase
    logic [RC_W-1:0]   r_rcnt;
    logic [31:0]       r_lfsr;
    logic              w_phase_n;
    logic [RC_W-1:0]   w_rcnt_n;
    logic [31:0]       w_lfsr_n;
`endif

    assign w_j_last      = (r_j == 4'd11);
    assign w_i_last      = (r_i == 4'd11);
    assign w_corner_last = w_j_last && w_i_last && (r_mode == 3'd5);

`ifdef FP_BIST_RANDOM_EN
    assign w_run_last = r_phase && (r_mode == 3'd5) && (r_rcnt == RC_LAST);
`else
    assign w_run_last = w_corner_last;
`endif

    assign w_sig_next = {signature[30:0],
                         signature[31] ^ signature[21] ^ signature[1] ^ signature[0]}
                        ^ z_i ^ {24'h0, status_i};

    assign pass = done && (signature == GOLDEN_SIG);

    // Next vector to present after the current capture (j innermost, mode outermost).
    always_comb begin
        // NOTE: every signal written here gets a value on every path so no latch is inferred.
        w_j_n    = w_j_last ? 4'd0 : r_j + 4'd1;
        w_i_n    = w_j_last ? (w_i_last ? 4'd0 : r_i + 4'd1) : r_i;
        w_mode_n = (w_j_last && w_i_last) ? r_mode + 3'd1 : r_mode;
        w_a_n    = corner_val(w_i_n);
        w_b_n    = corner_val(w_j_n);
        w_rnd_n  = w_mode_n;
`ifdef FP_BIST_RANDOM_EN
        w_phase_n = r_phase;
        w_rcnt_n  = r_rcnt;
        w_lfsr_n  = r_lfsr;
        if (r_phase || w_corner_last) begin
            w_phase_n = 1'b1;
            w_i_n     = r_i;
            w_j_n     = r_j;
            if (!r_phase) begin
                w_mode_n = 3'd0;
                w_rcnt_n = '0;
            end else if (r_rcnt == RC_LAST) begin
                w_mode_n = r_mode + 3'd1;
                w_rcnt_n = '0;
            end else begin
                w_mode_n = r_mode;
                w_rcnt_n = r_rcnt + 1'b1;
            end
            w_a_n    = lfsr_step(r_lfsr);
            w_b_n    = lfsr_step(w_a_n);
            w_lfsr_n = w_b_n;
            w_rnd_n  = w_mode_n;
        end
`endif
    end

    // Run sequencer: vector drive, latency wait, capture into the MISR, abort handling.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state uses non-blocking assignments only, and every register is
        // reset so outputs are defined before the first start.
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_mode    <= 3'd0;
            r_i       <= 4'd0;
            r_j       <= 4'd0;
            a_o       <= 32'h0000_0000;
            b_o       <= 32'h0000_0000;
            rnd_o     <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_count <= 11'd0;
            signature <= SIG_INIT;
`ifdef FP_BIST_RANDOM_EN
            r_phase   <= 1'b0;
            r_rcnt    <= '0;
            r_lfsr    <= LFSR_SEED;
`endif
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    // abort outranks a coincident start
                    if (start && !abort) begin
                        r_state   <= S_DRIVE;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        signature <= SIG_INIT;
                        vec_count <= 11'd0;
                        r_mode    <= 3'd0;
                        r_i       <= 4'd0;
                        r_j       <= 4'd0;
                        a_o       <= corner_val(4'd0);
                        b_o       <= corner_val(4'd0);
                        rnd_o     <= 3'd0;
`ifdef FP_BIST_RANDOM_EN
                        r_phase   <= 1'b0;
                        r_rcnt    <= '0;
                        r_lfsr    <= LFSR_SEED;
`endif
                    end
                end
                S_DRIVE, S_WAIT, S_CAPTURE: begin
                    if (abort) begin
                        // signature and vec_count are left as they are for inspection
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (r_state == S_DRIVE) begin
                        r_state <= S_WAIT;
                        r_wait  <= '0;
                    end else if (r_state == S_WAIT) begin
                        if (r_wait == WAIT_LAST) begin
                            r_state <= S_CAPTURE;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end else begin
                        signature <= w_sig_next;
                        if (vec_count != VEC_MAX_W) begin
                            vec_count <= vec_count + 11'd1;
                        end
                        if (w_run_last) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_DRIVE;
                            r_mode  <= w_mode_n;
                            r_i     <= w_i_n;
                            r_j     <= w_j_n;
                            a_o     <= w_a_n;
                            b_o     <= w_b_n;
                            rnd_o   <= w_rnd_n;
`ifdef FP_BIST_RANDOM_EN
                            r_phase <= w_phase_n;
                            r_rcnt  <= w_rcnt_n;
                            r_lfsr  <= w_lfsr_n;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_bist.sv
// Self-checking bench for fp_mult_bist (default build, LATENCY=2).
// The bench plays the multiplier: it drives random z_i/status_i every cycle,
// and a reference model folds the values present at each capture edge.
module tb_fp_mult_bist;

    localparam int unsigned LAT      = 2;
    localparam int unsigned SPAN     = LAT + 2;
    localparam int unsigned N_CORNER = 864;
    localparam logic [31:0] GOLDEN   = 32'hC0DE_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [2:0]  rnd_o;
    logic [31:0] z_i;
    logic [7:0]  status_i;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] vec_count;
    logic [31:0] signature;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          busy_cycles;
    logic [31:0] model_sig;
    logic [39:0] z_hist[$];
    logic [31:0] corner_tbl [12];

    fp_mult_bist #(
        .LATENCY   (LAT),
        .GOLDEN_SIG(GOLDEN),
        .RAND_COUNT(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .a_o      (a_o),
        .b_o      (b_o),
        .rnd_o    (rnd_o),
        .z_i      (z_i),
        .status_i (status_i),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .vec_count(vec_count),
        .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    // MISR rule: shift left, feedback = parity of taps 31,21,1,0, then xor in result and status.
    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] z, input logic [7:0] st);
        logic fb;
        fb = ^(s & 32'h8020_0003);
        return ((s << 1) | {31'h0, fb}) ^ z ^ {24'h0, st};
    endfunction

    // Vector n of the corner phase: n = mode*144 + i*12 + j.
    function automatic logic [31:0] exp_a(input int n);
        return corner_tbl[(n / 12) % 12];
    endfunction
    function automatic logic [31:0] exp_b(input int n);
        return corner_tbl[n % 12];
    endfunction
    function automatic logic [31:0] exp_rnd(input int n);
        return 32'(n / 144);
    endfunction

    // Start a run at a negedge and step through n_vec vectors.
    // zmode 0: random results (first forced to 1, last steered to GOLDEN), recorded;
    // zmode 1: replay the recorded results with one bit flipped in vector flip_vec;
    // zmode 2: random results, not recorded.
    task automatic run_corner(input int n_vec, input int zmode, input int flip_vec);
        logic [31:0] zv;
        logic [7:0]  sv;
        logic [39:0] e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_sig   = 32'hFFFF_FFFF;
        busy_cycles = 0;
        check("start_vec_count", 32'(vec_count), 32'd0);
        check("start_sig", signature, 32'hFFFF_FFFF);
        check("start_done", 32'(done), 32'd0);
        for (int v = 0; v < n_vec; v++) begin
            check($sformatf("a_o[%0d]", v), a_o, exp_a(v));
            check($sformatf("b_o[%0d]", v), b_o, exp_b(v));
            check($sformatf("rnd_o[%0d]", v), 32'(rnd_o), exp_rnd(v));
            if (zmode == 1) begin
                e  = z_hist[v];
                sv = e[39:32];
                zv = e[31:0];
                if (v == flip_vec) zv[7] = ~zv[7];
            end else if (zmode == 0 && v == 0) begin
                zv = 32'h0000_0001;
                sv = 8'h00;
            end else if (zmode == 0 && v == int'(N_CORNER) - 1) begin
                zv = misr(model_sig, 32'h0, 8'h0) ^ GOLDEN;
                sv = 8'h00;
            end else begin
                zv = $urandom;
                sv = 8'($urandom_range(0, 255));
            end
            if (zmode == 0) z_hist.push_back({sv, zv});
            for (int c = 0; c < int'(SPAN); c++) begin
                if (busy) busy_cycles++;
                start = (zmode == 0 && v == 100 && c == 1);
                if (c == int'(SPAN) - 1) begin
                    z_i      = zv;
                    status_i = sv;
                end else begin
                    z_i      = $urandom;
                    status_i = 8'($urandom_range(0, 255));
                end
                @(negedge clk);
            end
            start = 1'b0;
            model_sig = misr(model_sig, zv, sv);
            check($sformatf("sig[%0d]", v), signature, model_sig);
            check($sformatf("vec_count[%0d]", v), 32'(vec_count), 32'(v + 1));
            if (zmode == 0 && v == 0) check("first_sig", signature, 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        corner_tbl = '{32'h7FA0_0000, 32'hFFA0_0000, 32'h7FC0_0000, 32'hFFC0_0000,
                       32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'hBF80_0000,
                       32'h0000_0001, 32'h8000_0001, 32'h0000_0000, 32'h8000_0000};
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        z_i      = 32'h0;
        status_i = 8'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_a_o", a_o, 32'h0);
        check("rst_b_o", b_o, 32'h0);
        check("rst_rnd_o", 32'(rnd_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_vec_count", 32'(vec_count), 32'd0);
        check("rst_sig", signature, 32'hFFFF_FFFF);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Full corner run, start pulsed mid-run, last result steered to GOLDEN
        run_corner(int'(N_CORNER), 0, -1);
        check("run1_done", 32'(done), 32'd1);
        check("run1_busy", 32'(busy), 32'd0);
        check("run1_pass", 32'(pass), 32'd1);
        check("run1_vec_count", 32'(vec_count), 32'd864);
        check("run1_busy_cycles", 32'(busy_cycles), 32'd3456);
        check("run1_last_a", a_o, 32'h8000_0000);
        check("run1_last_b", b_o, 32'h8000_0000);
        check("run1_last_rnd", 32'(rnd_o), 32'd5);
        repeat (3) @(negedge clk);
        check("done_sticky", 32'(done), 32'd1);
        check("done_sig_hold", signature, GOLDEN);

        // Same results with one corrupted bit
        run_corner(int'(N_CORNER), 1, 500);
        check("run2_done", 32'(done), 32'd1);
        check("run2_pass", 32'(pass), 32'd0);
        check("run2_sig_model", signature, model_sig);

        // Abort at vec_count = 10
        run_corner(10, 2, -1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_vec_count", 32'(vec_count), 32'd10);
        check("abort_sig", signature, model_sig);
        repeat (5) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_vec", 32'(vec_count), 32'd10);

        // abort and start together: start is not accepted
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("prio_busy", 32'(busy), 32'd0);
        check("prio_vec_count", 32'(vec_count), 32'd10);

        // Asynchronous reset mid-run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_a_o", a_o, 32'h0);
        check("arst_b_o", b_o, 32'h0);
        check("arst_rnd_o", 32'(rnd_o), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_pass", 32'(pass), 32'd0);
        check("arst_vec_count", 32'(vec_count), 32'd0);
        check("arst_sig", signature, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_a_o", a_o, 32'h0);
        check("post_rst_vec", 32'(vec_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
